alu_16bit_response_checker: RTL and testbench
=============================================

// Module: alu_16bit_response_checker
// PURPOSE
// - Synthesizable golden-model response checker for the 16-bit ALU; it is the receive/compare end of the ALU stimulus stream.
// - Taps the ALU operand/op inputs and the ALU outputs.
// - Recomputes the expected result and flags, and delays them to match the DUT latency.
// - Compares, counts and latches a Trojan alarm on divergence.
// PARAMETERS
// - LATENCY       1   DUT cycles from operand apply to valid outputs; legal 1..4.
// - CNT_W        16   Width of the check and error counters.
// - ALARM_THRESH  1   Error count at which alarm latches; legal 1..2^CNT_W-1.
// PORTS
// - clk           in   1      Single clock, rising edge.
// - rst_n         in   1      Asynchronous, active-low reset.
// - clr           in   1      Synchronous clear of counters, alarm and capture; pipe untouched.
// - in_valid      in   1      A/B/op this cycle form a vector to check.
// - A, B          in   16     ALU operands as applied to the DUT.
// - op            in   2      00 ADD, 01 SUB, 10 AND, 11 OR.
// - dut_result    in   16     DUT outputs, sampled LATENCY cycles after their vector.
// - dut_carry, dut_zero, dut_overflow, dut_negative   in   1 each   DUT flags, sampled with dut_result.
// - mismatch      out  1      One-cycle pulse per failing vector.
// - alarm         out  1      Latched Trojan-detect flag.
// - state         out  2      00 IDLE, 01 RUN, 10 ALARM.
// - check_count   out  CNT_W  Vectors compared; saturates at all-ones.
// - err_count     out  CNT_W  Vectors failed; saturates at all-ones.
// - first_err     out  34     {op,A,B} of the first failing vector since reset/clr.
// BEHAVIOUR
// - Reset (rst_n=0, async):
//   - All outputs, counters, first_err and pipe valid bits clear to 0.
//   - state = IDLE.
// - Golden model (17-bit arithmetic):
//   - ADD: {carry,res} = A+B; overflow = (A[15]==B[15]) && (res[15]!=A[15]).
//   - SUB: {carry,res} = {1'b0,A} - {1'b0,B}, so carry = borrow (1 iff A<B); overflow = (A[15]!=B[15]) && (res[15]!=A[15]).
//   - AND/OR: bitwise; carry = 0, overflow = 0.
//   - All ops: zero = (res==0); negative = res[15].
// - Pipe:
//   - Expected {valid, op, A, B, res, flags} is computed at the edge ending cycle t.
//   - It shifts through LATENCY stages.
//   - The compare occurs in cycle t+LATENCY against the dut_* values present in that cycle.
//   - The pipe accepts a new vector every cycle; full throughput, no back-pressure.
// - Outcome is registered; mismatch, counters and first_err update at the edge ending cycle t+LATENCY.
//   - Visible in cycle t+LATENCY+1.
// - Every compare increments check_count; a fail also increments err_count. Both saturate and never wrap.
// - first_err loads only when err_count==0 at the failing compare.
// - FSM:
//   - IDLE->RUN on the first compare.
//   - RUN->ALARM when err_count reaches ALARM_THRESH.
//   - ALARM holds (alarm=1) until clr or reset.
//   - clr -> IDLE and overrides a compare in the same cycle; that compare is dropped from the counters.
// - in_valid=0 cycles insert bubbles; no compare, no count.
// - Reset mid-stream discards all in-flight vectors.
// CONFIGURATION
// - FLAG_CHECK_EN defined: a fail is any difference in result, carry, zero, overflow or negative.
// - FLAG_CHECK_EN undefined: only dut_result is compared; flag inputs are ignored (unused).
// TESTING (LATENCY=1; FLAG_CHECK_EN defined unless noted)
// - Reset, then A=FFFF B=FFFF op=00 and A=8000 B=8000 op=00 against a clean DUT:
//   - Exp FFFE c1 z0 v0 n1, then 0000 c1 z1 v1 n0.
//   - check_count=2, err_count=0, state=RUN.
// - A=FFFF B=0001 op=01, A=AAAA B=5555 op=10, then op=11 against a clean DUT:
//   - Exp FFFE c0, 0000 z1, FFFF n1.
//   - No mismatch.
// - Force dut_result=0001 on vector A=0002 B=0002 op=00:
//   - mismatch pulses exactly 1 cycle in cycle t+2.
//   - err_count=1, alarm=1, state=ALARM.
//   - first_err={2'b00,16'h0002,16'h0002}.
// - ALARM_THRESH=3, 2048 random vectors, with 5 vectors corrupted by flipping dut_zero only:
//   - FLAG_CHECK_EN defined: err_count=5, alarm=1.
//   - FLAG_CHECK_EN undefined: err_count=0, alarm=0.
//   - Either build: check_count=2048.
// - Counter saturation and clear:
//   - CNT_W=4, 20 back-to-back failing vectors: err_count holds at F and does not wrap.
//   - clr asserted together with a compare: all counters 0, state=IDLE.
//   - rst_n dropped mid-stream: outputs 0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/alu_16bit_response_checker.sv
// Golden-model response checker for the 16-bit ALU: recomputes result/flags, delays them
// LATENCY cycles, compares against the DUT and latches an alarm. Optional: FLAG_CHECK_EN.
module alu_16bit_response_checker #(
    parameter int LATENCY      = 1,
    parameter int CNT_W        = 16,
    parameter int ALARM_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [15:0]      A,
    input  logic [15:0]      B,
    input  logic [1:0]       op,
    input  logic [15:0]      dut_result,
    input  logic             dut_carry,
    input  logic             dut_zero,
    input  logic             dut_overflow,
    input  logic             dut_negative,
    output logic             mismatch,
    output logic             alarm,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] check_count,
    output logic [CNT_W-1:0] err_count,
    output logic [33:0]      first_err
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_RUN   = 2'b01;
    localparam logic [1:0] ST_ALARM = 2'b10;
    localparam logic [CNT_W-1:0] THR = CNT_W'(ALARM_THRESH);

    typedef struct packed {
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
        logic        v;
        logic        n;
    } exp_t;

    logic [16:0]       sum;
    exp_t              gold;
    logic [LATENCY:1]  vld_pipe;
    exp_t              exp_pipe [1:LATENCY];
    exp_t              tail;
    logic              do_cmp;
    logic              fail;
    logic              hit;
    logic [CNT_W-1:0]  err_next;
    logic [1:0]        nxt_state;

    always_comb begin
        sum     = '0;
        gold    = '0;
        gold.op = op;
        gold.a  = A;
        gold.b  = B;
        case (op)
            2'b00: begin
                sum      = {1'b0, A} + {1'b0, B};
                gold.res = sum[15:0];
                gold.c   = sum[16];
                gold.v   = (A[15] == B[15]) && (sum[15] != A[15]);
            end
            2'b01: begin
                // bit 16 of the 17-bit difference is the borrow (A < B)
                sum      = {1'b0, A} - {1'b0, B};
                gold.res = sum[15:0];
                gold.c   = sum[16];
                gold.v   = (A[15] != B[15]) && (sum[15] != A[15]);
            end
            2'b10:   gold.res = A & B;
            default: gold.res = A | B;
        endcase
        gold.z = (gold.res == 16'h0000);
        gold.n = gold.res[15];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            for (int i = 1; i <= LATENCY; i++) exp_pipe[i] <= '0;
        end else begin
            vld_pipe[1] <= in_valid;
            exp_pipe[1] <= gold;
            for (int i = 2; i <= LATENCY; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
                exp_pipe[i] <= exp_pipe[i-1];
            end
        end
    end

    assign tail   = exp_pipe[LATENCY];
    assign do_cmp = vld_pipe[LATENCY];

`ifdef FLAG_CHECK_EN
    assign fail = (dut_result != tail.res) || (dut_carry != tail.c) || (dut_zero != tail.z) ||
                  (dut_overflow != tail.v) || (dut_negative != tail.n);
`else
    logic unused_flags;
    assign fail         = (dut_result != tail.res);
    assign unused_flags = ^{dut_carry, dut_zero, dut_overflow, dut_negative,
                            tail.c, tail.z, tail.v, tail.n};
`endif

    assign err_next = (do_cmp && fail && !(&err_count)) ? err_count + CNT_W'(1) : err_count;
    assign hit      = do_cmp && fail && (err_next >= THR);

    always_comb begin
        nxt_state = state;
        case (state)
            ST_IDLE: if (do_cmp) nxt_state = hit ? ST_ALARM : ST_RUN;
            ST_RUN:  if (hit) nxt_state = ST_ALARM;
            default: nxt_state = ST_ALARM;
        endcase
    end

    assign alarm = (state == ST_ALARM);

    // clr wins over a same-cycle compare: that outcome is simply dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch    <= 1'b0;
            state       <= ST_IDLE;
            check_count <= '0;
            err_count   <= '0;
            first_err   <= '0;
        end else if (clr) begin
            mismatch    <= 1'b0;
            state       <= ST_IDLE;
            check_count <= '0;
            err_count   <= '0;
            first_err   <= '0;
        end else begin
            mismatch  <= do_cmp && fail;
            state     <= nxt_state;
            err_count <= err_next;
            if (do_cmp && !(&check_count)) check_count <= check_count + CNT_W'(1);
            if (do_cmp && fail && (err_count == '0)) first_err <= {tail.op, tail.a, tail.b};
        end
    end

endmodule

// File: tb/tb_alu_16bit_response_checker.sv
// Directed bench for alu_16bit_response_checker: two instances (CNT_W=4/THRESH=1 and
// CNT_W=16/THRESH=3) share the stimulus; DUT responses are hand-computed or table-driven.
module tb_alu_16bit_response_checker;

`ifdef FLAG_CHECK_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, clr, in_valid;
    logic [15:0] a, b, dres;
    logic [1:0]  op;
    logic        dc, dz, dv, dn;

    logic        u1_mm, u1_al, u3_mm, u3_al;
    logic [1:0]  u1_st, u3_st;
    logic [3:0]  u1_cc, u1_ec;
    logic [15:0] u3_cc, u3_ec;
    logic [33:0] u1_fe, u3_fe;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_16bit_response_checker #(.LATENCY(1), .CNT_W(4), .ALARM_THRESH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .A(a), .B(b), .op(op),
        .dut_result(dres), .dut_carry(dc), .dut_zero(dz), .dut_overflow(dv), .dut_negative(dn),
        .mismatch(u1_mm), .alarm(u1_al), .state(u1_st), .check_count(u1_cc),
        .err_count(u1_ec), .first_err(u1_fe));

    alu_16bit_response_checker #(.LATENCY(1), .CNT_W(16), .ALARM_THRESH(3)) u3 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .A(a), .B(b), .op(op),
        .dut_result(dres), .dut_carry(dc), .dut_zero(dz), .dut_overflow(dv), .dut_negative(dn),
        .mismatch(u3_mm), .alarm(u3_al), .state(u3_st), .check_count(u3_cc),
        .err_count(u3_ec), .first_err(u3_fe));

    // f = {carry, zero, overflow, negative}; r/f answer the vector of the previous cycle
    task automatic tick(input logic v, input logic [15:0] ta, input logic [15:0] tb,
                        input logic [1:0] to, input logic [15:0] r, input logic [3:0] f);
        in_valid = v; a = ta; b = tb; op = to; dres = r;
        {dc, dz, dv, dn} = f;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; clr = 1'b0;
        tick(0, 0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
    endtask

    function automatic logic [19:0] alu_ref(input logic [15:0] x, input logic [15:0] y,
                                            input logic [1:0] o);
        logic [15:0] r;
        logic        c, v;
        int          s;
        c = 1'b0; v = 1'b0; s = 0; r = '0;
        case (o)
            2'd0: begin
                r = x + y;
                s = int'($signed(x)) + int'($signed(y));
                c = (32'(x) + 32'(y)) > 32'h0000_FFFF;
                v = (s > 32767) || (s < -32768);
            end
            2'd1: begin
                r = x - y;
                s = int'($signed(x)) - int'($signed(y));
                c = (x < y);
                v = (s > 32767) || (s < -32768);
            end
            2'd2: r = x & y;
            default: r = x | y;
        endcase
        return {r, c, (r == 16'h0000), v, r[15]};
    endfunction

    task automatic test_reset();
        do_reset();
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL reset_mismatch got %0h exp 0", u1_mm); end
        checks++; if (u1_al !== 1'b0) begin errors++; $display("FAIL reset_alarm got %0h exp 0", u1_al); end
        checks++; if (u1_st !== 2'b00) begin errors++; $display("FAIL reset_state got %0h exp 0", u1_st); end
        checks++; if ({u1_cc, u1_ec, u1_fe} !== '0) begin errors++; $display("FAIL reset_counters cc %0h ec %0h fe %0h exp 0", u1_cc, u1_ec, u1_fe); end
    endtask

    task automatic test_add();
        do_reset();
        tick(1, 16'hFFFF, 16'hFFFF, 2'b00, 16'h0000, 4'b0000);
        tick(1, 16'h8000, 16'h8000, 2'b00, 16'hFFFE, 4'b1001);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL add_ffff got %0h exp 0", u1_mm); end
        tick(0, 0, 0, 0, 16'h0000, 4'b1110);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL add_8000 got %0h exp 0", u1_mm); end
        checks++; if (u1_cc !== 4'd2) begin errors++; $display("FAIL add_check_count got %0h exp 2", u1_cc); end
        checks++; if (u1_ec !== 4'd0) begin errors++; $display("FAIL add_err_count got %0h exp 0", u1_ec); end
        checks++; if (u1_st !== 2'b01) begin errors++; $display("FAIL add_state got %0h exp 1", u1_st); end
    endtask

    task automatic test_sub_logic();
        do_reset();
        tick(1, 16'hFFFF, 16'h0001, 2'b01, 16'h0000, 4'b0000);
        tick(1, 16'hAAAA, 16'h5555, 2'b10, 16'hFFFE, 4'b0001);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL sub got %0h exp 0", u1_mm); end
        tick(1, 16'hAAAA, 16'h5555, 2'b11, 16'h0000, 4'b0100);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL and got %0h exp 0", u1_mm); end
        tick(0, 0, 0, 0, 16'hFFFF, 4'b0001);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL or got %0h exp 0", u1_mm); end
        // bubble with a garbage response: must not be compared
        tick(0, 0, 0, 0, 16'h1234, 4'b1111);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL bubble_mismatch got %0h exp 0", u1_mm); end
        checks++; if (u1_cc !== 4'd3) begin errors++; $display("FAIL bubble_check_count got %0h exp 3", u1_cc); end
        // SUB borrow: 0001 - 0002 = FFFF, c1 n1
        tick(1, 16'h0001, 16'h0002, 2'b01, 16'h0000, 4'b0000);
        tick(0, 0, 0, 0, 16'hFFFF, 4'b1001);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL sub_borrow got %0h exp 0", u1_mm); end
        // SUB overflow: 8000 - 0001 = 7FFF, v1
        tick(1, 16'h8000, 16'h0001, 2'b01, 16'h0000, 4'b0000);
        tick(0, 0, 0, 0, 16'h7FFF, 4'b0010);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL sub_overflow got %0h exp 0", u1_mm); end
        checks++; if (u1_ec !== 4'd0) begin errors++; $display("FAIL sub_logic_err_count got %0h exp 0", u1_ec); end
    endtask

    task automatic test_fail();
        do_reset();
        tick(1, 16'h0002, 16'h0002, 2'b00, 16'h0000, 4'b0000);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL fail_early got %0h exp 0", u1_mm); end
        tick(0, 0, 0, 0, 16'h0001, 4'b0000);
        checks++; if (u1_mm !== 1'b1) begin errors++; $display("FAIL fail_pulse got %0h exp 1", u1_mm); end
        tick(0, 0, 0, 0, 16'h0001, 4'b0000);
        checks++; if (u1_mm !== 1'b0) begin errors++; $display("FAIL fail_pulse_end got %0h exp 0", u1_mm); end
        checks++; if (u1_ec !== 4'd1) begin errors++; $display("FAIL fail_err_count got %0h exp 1", u1_ec); end
        checks++; if (u1_al !== 1'b1) begin errors++; $display("FAIL fail_alarm got %0h exp 1", u1_al); end
        checks++; if (u1_st !== 2'b10) begin errors++; $display("FAIL fail_state got %0h exp 2", u1_st); end
        checks++; if (u1_fe !== 34'h0_0002_0002) begin errors++; $display("FAIL fail_first_err got %0h exp 000020002", u1_fe); end
        checks++; if (u3_al !== 1'b0 || u3_st !== 2'b01) begin errors++; $display("FAIL fail_thresh3 alarm %0h state %0h exp 0 1", u3_al, u3_st); end
        // second failure must not overwrite first_err
        tick(1, 16'h0003, 16'h0001, 2'b01, 16'h0000, 4'b0000);
        tick(0, 0, 0, 0, 16'h0005, 4'b0000);
        checks++; if (u1_ec !== 4'd2) begin errors++; $display("FAIL fail2_err_count got %0h exp 2", u1_ec); end
        checks++; if (u1_fe !== 34'h0_0002_0002) begin errors++; $display("FAIL fail2_first_err got %0h exp 000020002", u1_fe); end
    endtask

    task automatic test_flags();
        logic [3:0] good;
        good = 4'b1110;                              // 8000+8000 = 0000 c1 z1 v1 n0
        do_reset();
        for (int k = 0; k < 4; k++) begin
            tick(1, 16'h8000, 16'h8000, 2'b00, 16'h0000, good);
            tick(0, 0, 0, 0, 16'h0000, good ^ (4'b0001 << k));
            checks++;
            if (u3_mm !== FLAGS) begin errors++; $display("FAIL flag_flip_%0d got %0h exp %0h", k, u3_mm, FLAGS); end
        end
        checks++; if (u3_ec !== (FLAGS ? 16'd4 : 16'd0)) begin errors++; $display("FAIL flag_err_count got %0h exp %0h", u3_ec, FLAGS ? 4 : 0); end
    endtask

    task automatic test_random();
        logic [19:0] prev;
        logic [15:0] ra, rb;
        logic [1:0]  ro;
        logic [3:0]  f;
        prev = '0;
        do_reset();
        for (int i = 0; i <= 2048; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); ro = 2'($urandom_range(3));
            f  = prev[3:0];
            if (i == 4 || i == 401 || i == 402 || i == 1001 || i == 2048) f[2] = ~f[2];
            tick(i < 2048, ra, rb, ro, prev[19:4], f);
            prev = alu_ref(ra, rb, ro);
        end
        checks++; if (u3_cc !== 16'd2048) begin errors++; $display("FAIL rand_check_count got %0d exp 2048", u3_cc); end
        checks++; if (u3_ec !== (FLAGS ? 16'd5 : 16'd0)) begin errors++; $display("FAIL rand_err_count got %0d exp %0d", u3_ec, FLAGS ? 5 : 0); end
        checks++; if (u3_al !== FLAGS) begin errors++; $display("FAIL rand_alarm got %0h exp %0h", u3_al, FLAGS); end
        checks++; if (u1_cc !== 4'hF) begin errors++; $display("FAIL rand_cc_saturate got %0h exp f", u1_cc); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i <= 20; i++) begin
            tick(i < 20, 16'h0001, 16'h0001, 2'b00, 16'h0000, 4'b0000);
            if (i >= 1) begin
                checks++;
                if (u1_mm !== 1'b1) begin errors++; $display("FAIL sat_mismatch_%0d got %0h exp 1", i, u1_mm); end
            end
        end
        checks++; if (u1_ec !== 4'hF) begin errors++; $display("FAIL sat_err_count got %0h exp f", u1_ec); end
        checks++; if (u1_cc !== 4'hF) begin errors++; $display("FAIL sat_check_count got %0h exp f", u1_cc); end
        checks++; if (u1_st !== 2'b10) begin errors++; $display("FAIL sat_state got %0h exp 2", u1_st); end
    endtask

    task automatic test_clr();
        tick(1, 16'h0001, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        clr = 1'b1;
        tick(1, 16'h0004, 16'h0004, 2'b10, 16'h0000, 4'b0000);
        clr = 1'b0;
        checks++; if ({u1_cc, u1_ec} !== 8'h00) begin errors++; $display("FAIL clr_counters cc %0h ec %0h exp 0 0", u1_cc, u1_ec); end
        checks++; if (u1_st !== 2'b00 || u1_al !== 1'b0) begin errors++; $display("FAIL clr_state state %0h alarm %0h exp 0 0", u1_st, u1_al); end
        checks++; if (u1_mm !== 1'b0 || u1_fe !== '0) begin errors++; $display("FAIL clr_capture mm %0h fe %0h exp 0 0", u1_mm, u1_fe); end
        tick(0, 0, 0, 0, 16'h0004, 4'b0000);
        checks++; if (u1_cc !== 4'd1 || u1_ec !== 4'd0 || u1_st !== 2'b01) begin errors++; $display("FAIL clr_pipe cc %0h ec %0h st %0h exp 1 0 1", u1_cc, u1_ec, u1_st); end
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1, 16'h0001, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        tick(0, 0, 0, 0, 16'h0009, 4'b0000);
        tick(1, 16'h0010, 16'h0001, 2'b00, 16'h0000, 4'b0000);
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({u1_mm, u1_al, u1_st, u1_cc, u1_ec, u1_fe} !== '0) begin errors++; $display("FAIL async_reset mm %0h al %0h st %0h cc %0h ec %0h fe %0h exp 0", u1_mm, u1_al, u1_st, u1_cc, u1_ec, u1_fe); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick(0, 0, 0, 0, 16'hDEAD, 4'b1111);
        tick(0, 0, 0, 0, 16'hDEAD, 4'b1111);
        checks++; if (u1_cc !== 4'd0 || u1_mm !== 1'b0) begin errors++; $display("FAIL async_inflight cc %0h mm %0h exp 0 0", u1_cc, u1_mm); end
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; op = '0; dres = '0;
        dc = 1'b0; dz = 1'b0; dv = 1'b0; dn = 1'b0;
        test_reset();
        test_add();
        test_sub_logic();
        test_fail();
        test_flags();
        test_random();
        test_saturation();
        test_clr();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
